// File: rtl/mem_access_sequencer_if.sv
// Purpose : load/store handshake bundle between ControlUnit, the sequencer and
//           the DataPath MAR/MDR/ram.
// Signals : req, op3[5:0], addr_lo[1:0], MFC        requester/ram -> sequencer
//           MAR_Enable, MDR_Enable, MDR_Mux_select,
//           RAM_enable, RAM_OpCode[5:0], busy,
//           done, trap, tt[2:0]                     sequencer -> datapath/ControlUnit
// Modports: slave  = sequencer side
//           master = ControlUnit/ram side
interface mem_access_sequencer_if;
    logic       req;
    logic [5:0] op3;
    logic [1:0] addr_lo;
    logic       MFC;
    logic       MAR_Enable;
    logic       MDR_Enable;
    logic       MDR_Mux_select;
    logic       RAM_enable;
    logic [5:0] RAM_OpCode;
    logic       busy;
    logic       done;
    logic       trap;
    logic [2:0] tt;

    modport slave (
        input  req, op3, addr_lo, MFC,
        output MAR_Enable, MDR_Enable, MDR_Mux_select, RAM_enable, RAM_OpCode,
               busy, done, trap, tt
    );

    modport master (
        output req, op3, addr_lo, MFC,
        input  MAR_Enable, MDR_Enable, MDR_Mux_select, RAM_enable, RAM_OpCode,
               busy, done, trap, tt
    );
endinterface

// File: rtl/mem_access_sequencer.sv
// Purpose : multi-cycle load/store sequencer. Latches the SPARC op3 on a request,
//           checks legality and alignment, strobes MAR/MDR, holds RAM_enable until
//           the ram raises MFC, captures load data into MDR and pulses done.
//           Bad accesses pulse trap with a trap type instead of touching RAM.
// Ports   : Clk      system clock, rising edge
//           RESET_n  asynchronous active-low reset
//           bus      mem_access_sequencer_if.slave (request, MFC, strobes, status)
// Params  : TIMEOUT_CYCLES  WAIT_MFC cycles before a timeout trap
//           CNT_W           wait counter width, must hold TIMEOUT_CYCLES-1
// Config  : MEM_TIMEOUT_EN  when defined, a stuck WAIT_MFC traps with tt=3;
//                           when undefined, WAIT_MFC waits indefinitely.
module mem_access_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5
) (
    input  logic                  Clk,
    input  logic                  RESET_n,
    mem_access_sequencer_if.slave bus
);

    localparam int unsigned OP_W = 6;
    localparam int unsigned TT_W = 3;

    localparam logic [TT_W-1:0] TT_NONE      = TT_W'(0);
    localparam logic [TT_W-1:0] TT_MISALIGN  = TT_W'(1);
    localparam logic [TT_W-1:0] TT_ILLEGAL   = TT_W'(2);
    localparam logic [TT_W-1:0] TT_TIMEOUT   = TT_W'(3);

    // Parameter sanity: the counter must be able to reach TIMEOUT_CYCLES-1.
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > (32'd1 << CNT_W)) begin : g_param_check
        $error("mem_access_sequencer: TIMEOUT_CYCLES does not fit CNT_W");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAR_LD,
        S_WAIT_MFC,
        S_CAPTURE,
        S_DONE,
        S_TRAP
    } state_e;

    state_e            state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [TT_W-1:0]   tt_q, tt_d;

    logic mar_en_q, mar_en_d;
    logic mdr_en_q, mdr_en_d;
    logic mux_sel_q, mux_sel_d;
    logic ram_en_q, ram_en_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic trap_q, trap_d;

    // Classification of the incoming op3.
    logic op_legal_c;
    logic op_word_c;
    logic op_half_c;

    always_comb begin
        op_legal_c = 1'b1;
        op_word_c  = 1'b0;
        op_half_c  = 1'b0;
        case (bus.op3)
            6'b000000, 6'b000100:             op_word_c  = 1'b1;
            6'b000010, 6'b000110, 6'b001010:  op_half_c  = 1'b1;
            6'b000001, 6'b000101, 6'b001001:  op_legal_c = 1'b1;
            default:                          op_legal_c = 1'b0;
        endcase
    end

    // Misaligned: word needs addr_lo==00, half needs addr_lo[0]==0.
    logic misaligned_c;
    assign misaligned_c = (op_word_c && (bus.addr_lo != 2'b00)) ||
                          (op_half_c && bus.addr_lo[0]);

`ifdef MEM_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // State / latch registers.
    always_ff @(posedge Clk or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            tt_q    <= TT_NONE;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            tt_q    <= tt_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    // Wait counter.
    always_ff @(posedge Clk or negedge RESET_n) begin
        if (!RESET_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        tt_d    = TT_NONE;
`ifdef MEM_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    op_d = bus.op3;
                    if (!op_legal_c) begin
                        state_d = S_TRAP;
                        tt_d    = TT_ILLEGAL;
                    end else if (misaligned_c) begin
                        state_d = S_TRAP;
                        tt_d    = TT_MISALIGN;
                    end else begin
                        state_d = S_MAR_LD;
                    end
                end
            end
            S_MAR_LD: begin
                state_d = S_WAIT_MFC;
`ifdef MEM_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT_MFC: begin
                if (bus.MFC) begin
                    // op3[2] distinguishes st/stb/sth from the loads.
                    state_d = op_q[2] ? S_DONE : S_CAPTURE;
`ifdef MEM_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_TRAP;
                    tt_d    = TT_TIMEOUT;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
`endif
                end
            end
            S_CAPTURE: state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            S_TRAP:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state, so the registered strobes line up with it.
    always_comb begin
        mar_en_d  = (state_d == S_MAR_LD);
        mdr_en_d  = ((state_d == S_MAR_LD) && op_d[2]) || (state_d == S_CAPTURE);
        mux_sel_d = (state_d == S_CAPTURE);
        ram_en_d  = (state_d == S_WAIT_MFC) || (state_d == S_CAPTURE);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        trap_d    = (state_d == S_TRAP);
    end

    // Output registers; async reset drops every strobe immediately.
    always_ff @(posedge Clk or negedge RESET_n) begin
        if (!RESET_n) begin
            mar_en_q  <= 1'b0;
            mdr_en_q  <= 1'b0;
            mux_sel_q <= 1'b0;
            ram_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            trap_q    <= 1'b0;
        end else begin
            mar_en_q  <= mar_en_d;
            mdr_en_q  <= mdr_en_d;
            mux_sel_q <= mux_sel_d;
            ram_en_q  <= ram_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            trap_q    <= trap_d;
        end
    end

    assign bus.MAR_Enable     = mar_en_q;
    assign bus.MDR_Enable     = mdr_en_q;
    assign bus.MDR_Mux_select = mux_sel_q;
    assign bus.RAM_enable     = ram_en_q;
    assign bus.RAM_OpCode     = op_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.trap           = trap_q;
    assign bus.tt             = tt_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Purpose : directed self-checking bench for mem_access_sequencer.
module tb_mem_access_sequencer;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    mem_access_sequencer_if bus ();

    mem_access_sequencer #(
        .TIMEOUT_CYCLES (16),
        .CNT_W          (5)
    ) dut (
        .Clk     (clk),
        .RESET_n (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one clock edge.
    task automatic start(input logic [5:0] op, input logic [1:0] a);
        bus.req     = 1'b1;
        bus.op3     = op;
        bus.addr_lo = a;
        tick();
        bus.req     = 1'b0;
    endtask

    task automatic expect_trap(input string tag, input logic [5:0] op, input logic [1:0] a,
                               input logic [2:0] exp_tt);
        start(op, a);
        check({tag, "_trap"}, 32'(bus.trap), 32'd1);
        check({tag, "_tt"}, 32'(bus.tt), 32'(exp_tt));
        check({tag, "_strobes"}, 32'({bus.MAR_Enable, bus.MDR_Enable, bus.RAM_enable, bus.done}), 32'd0);
        tick();
        check({tag, "_idle"}, 32'({bus.busy, bus.trap, bus.tt}), 32'd0);
    endtask

    int dones;
    int waits;
    logic seen_trap;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        bus.req = 1'b0;
        bus.op3 = '0;
        bus.addr_lo = '0;
        bus.MFC = 1'b0;
        rst_n = 1'b0;
        #1;
        check("reset_outputs", 32'({bus.MAR_Enable, bus.MDR_Enable, bus.MDR_Mux_select,
              bus.RAM_enable, bus.busy, bus.done, bus.trap, bus.tt}), 32'd0);
        check("reset_opcode", 32'(bus.RAM_OpCode), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_busy", 32'(bus.busy), 32'd0);

        // Store word, MFC on the second WAIT cycle.
        start(6'b000100, 2'b00);
        check("st_marld", 32'({bus.MAR_Enable, bus.MDR_Enable, bus.MDR_Mux_select, bus.RAM_enable, bus.busy}),
              32'b11001);
        tick();
        check("st_wait1", 32'({bus.MAR_Enable, bus.MDR_Enable, bus.RAM_enable}), 32'b001);
        check("st_opcode", 32'(bus.RAM_OpCode), 32'h04);
        tick();
        check("st_wait2", 32'(bus.RAM_enable), 32'd1);
        bus.MFC = 1'b1;
        tick();
        bus.MFC = 1'b0;
        check("st_done", 32'({bus.done, bus.RAM_enable, bus.trap, bus.busy}), 32'b1001);
        tick();
        check("st_idle", 32'({bus.done, bus.busy}), 32'd0);

        // Load word with MFC tied high: done in the 4th cycle after the request edge.
        bus.MFC = 1'b1;
        start(6'b000000, 2'b00);
        check("ld_marld", 32'({bus.MAR_Enable, bus.MDR_Enable, bus.RAM_enable}), 32'b100);
        tick();
        check("ld_wait", 32'({bus.MAR_Enable, bus.RAM_enable, bus.done}), 32'b010);
        tick();
        check("ld_capture", 32'({bus.MDR_Enable, bus.MDR_Mux_select, bus.RAM_enable, bus.done}), 32'b1110);
        tick();
        check("ld_done", 32'({bus.done, bus.RAM_enable, bus.MDR_Enable}), 32'b100);
        bus.MFC = 1'b0;
        tick();
        check("ld_idle", 32'(bus.busy), 32'd0);

        // Trap cases, including illegal-op priority over misalignment.
        expect_trap("lduh_mis", 6'b000010, 2'b01, 3'd1);
        expect_trap("ld_mis", 6'b000000, 2'b10, 3'd1);
        expect_trap("illegal", 6'b111111, 2'b00, 3'd2);
        expect_trap("illegal_prio", 6'b000011, 2'b01, 3'd2);

        // Aligned sth at addr 10 is legal; ignored req during WAIT; exactly one done.
        start(6'b000110, 2'b10);
        check("sth_marld", 32'({bus.MAR_Enable, bus.MDR_Enable, bus.trap}), 32'b110);
        tick();
        bus.req = 1'b1;
        bus.op3 = 6'b111111;
        tick();
        bus.req = 1'b0;
        check("sth_req_ignored", 32'({bus.RAM_enable, bus.trap}), 32'b10);
        check("sth_opcode_kept", 32'(bus.RAM_OpCode), 32'h06);
        bus.MFC = 1'b1;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            bus.MFC = 1'b0;
            if (bus.done) dones++;
            check("no_trap_window", 32'(bus.trap), 32'd0);
        end
        check("one_done", 32'(dones), 32'd1);

        // Async reset mid-WAIT_MFC drops everything without a clock edge.
        start(6'b001010, 2'b00);
        tick();
        tick();
        check("pre_rst_wait", 32'(bus.RAM_enable), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", 32'({bus.MAR_Enable, bus.MDR_Enable, bus.RAM_enable, bus.busy,
              bus.done, bus.trap}), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_idle", 32'(bus.busy), 32'd0);

`ifdef MEM_TIMEOUT_EN
        // MFC stuck low: trap tt=3 after 16 WAIT cycles.
        start(6'b000001, 2'b11);
        waits = 0;
        seen_trap = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.trap) begin
                seen_trap = 1'b1;
                break;
            end
            if (bus.RAM_enable) waits++;
        end
        check("to_seen", 32'(seen_trap), 32'd1);
        check("to_waits", 32'(waits), 32'd16);
        check("to_tt", 32'(bus.tt), 32'd3);
        check("to_ram_off", 32'({bus.RAM_enable, bus.done}), 32'd0);
        tick();
        // MFC arriving on the 16th WAIT cycle wins over the timeout.
        start(6'b000000, 2'b00);
        for (int i = 1; i <= 16; i++) tick();
        check("to16_wait", 32'(bus.RAM_enable), 32'd1);
        bus.MFC = 1'b1;
        tick();
        bus.MFC = 1'b0;
        check("to16_capture", 32'({bus.MDR_Enable, bus.trap}), 32'b10);
        tick();
        check("to16_done", 32'({bus.done, bus.trap}), 32'b10);
        tick();
`else
        // Without the timeout, a long MFC wait never traps.
        start(6'b000000, 2'b00);
        seen_trap = 1'b0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (bus.trap) seen_trap = 1'b1;
        end
        check("long_wait_notrap", 32'(seen_trap), 32'd0);
        check("long_wait_ram", 32'(bus.RAM_enable), 32'd1);
        bus.MFC = 1'b1;
        tick();
        bus.MFC = 1'b0;
        tick();
        check("long_wait_done", 32'(bus.done), 32'd1);
        tick();
`endif
        check("final_idle", 32'(bus.busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
